// File: rtl/register_file_pkg.sv
// Shared register-map constants for the waveform-generator register file:
// addresses, CTRL/STATUS bit positions, default widths and the ID constant.
package register_file_pkg;

  localparam int RF_ADDR_WIDTH = 7;
  localparam int RF_DATA_WIDTH = 8;

  // Only the low three address bits select a register; everything above must be 0.
  localparam int RF_REG_SEL_BITS = 3;

  typedef enum logic [2:0] {
    RF_ADDR_CTRL   = 3'd0,
    RF_ADDR_STATUS = 3'd1,
    RF_ADDR_FREQ_L = 3'd2,
    RF_ADDR_FREQ_M = 3'd3,
    RF_ADDR_FREQ_H = 3'd4,
    RF_ADDR_AMPL   = 3'd5,
    RF_ADDR_OFFS   = 3'd6,
    RF_ADDR_ID     = 3'd7
  } rf_addr_e;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_START_BIT  = 1;
  localparam int CTRL_WAVE_LSB   = 2;
  localparam int CTRL_WAVE_MSB   = 3;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_ERR_BIT  = 1;

  localparam logic [7:0] RF_ID_VALUE = 8'hA5;

  // Registers that accept a host write; STATUS and ID are read-only.
  function automatic logic is_writable(input rf_addr_e sel);
    return (sel != RF_ADDR_STATUS) && (sel != RF_ADDR_ID);
  endfunction

  // Registers whose write counts as a configuration update to the generator.
  function automatic logic is_update_reg(input rf_addr_e sel);
    return (sel == RF_ADDR_CTRL) || (sel == RF_ADDR_FREQ_H) ||
           (sel == RF_ADDR_AMPL) || (sel == RF_ADDR_OFFS);
  endfunction

endpackage

// File: rtl/register_file.sv
// Host-visible register file for the waveform generator: decodes single-cycle
// read/write strobes, stages and atomically commits the phase increment, and tracks a sticky ERR flag.
module register_file
  import register_file_pkg::*;
#(
  parameter int                    ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = RF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DATA_WIDTH'(RF_ID_VALUE)
) (
  input  logic                  sys_clk_i,
  input  logic                  sys_rst_i,
  input  logic                  rf_we_i,
  input  logic                  rf_re_i,
  input  logic [ADDR_WIDTH-1:0] rf_addr_i,
  input  logic [DATA_WIDTH-1:0] rf_data_i,
  output logic [DATA_WIDTH-1:0] rf_data_o,
  output logic                  rf_rd_dv_o,
  input  logic                  gen_busy_i,
  output logic                  gen_en_o,
  output logic                  gen_start_o,
  output logic [1:0]            gen_wave_o,
  output logic [23:0]           gen_phinc_o,
  output logic [DATA_WIDTH-1:0] gen_ampl_o,
  output logic [DATA_WIDTH-1:0] gen_offs_o,
  output logic                  gen_upd_o
);

  // Strobe protocol: rf_we_i / rf_re_i are one-cycle requests with no backpressure.
  // A write takes effect on the edge it is sampled; a read answers with rf_data_o
  // and a one-cycle rf_rd_dv_o on the following cycle. If both strobes are high
  // together the write wins and the read is discarded.

  // ---------------------------------------------------------------------------
  // Address decode and request classification
  // ---------------------------------------------------------------------------
  logic     addr_mapped;
  rf_addr_e reg_sel;
  logic     wr_ok;
  logic     rd_ok;
  logic     wr_err;
  logic     rd_err;
  logic     col_err;
  logic     status_rd;

  assign addr_mapped = (rf_addr_i >> RF_REG_SEL_BITS) == '0;
  assign reg_sel     = rf_addr_e'(rf_addr_i[RF_REG_SEL_BITS-1:0]);

  assign wr_ok     = rf_we_i & addr_mapped & is_writable(reg_sel);
  assign wr_err    = rf_we_i & ~wr_ok;
  assign rd_ok     = rf_re_i & ~rf_we_i;
  assign rd_err    = rd_ok & ~addr_mapped;
  assign col_err   = rf_we_i & rf_re_i;
  assign status_rd = rd_ok & addr_mapped & (reg_sel == RF_ADDR_STATUS);

  // ---------------------------------------------------------------------------
  // Write / commit
  // ---------------------------------------------------------------------------
  logic                  ctrl_en_d,   ctrl_en_q;
  logic [1:0]            ctrl_wave_d, ctrl_wave_q;
  logic [DATA_WIDTH-1:0] freq_l_d,    freq_l_q;
  logic [DATA_WIDTH-1:0] freq_m_d,    freq_m_q;
  logic [DATA_WIDTH-1:0] freq_h_d,    freq_h_q;
  logic [23:0]           phinc_d,     phinc_q;
  logic [DATA_WIDTH-1:0] ampl_d,      ampl_q;
  logic [DATA_WIDTH-1:0] offs_d,      offs_q;

  always_comb begin
    ctrl_en_d   = ctrl_en_q;
    ctrl_wave_d = ctrl_wave_q;
    freq_l_d    = freq_l_q;
    freq_m_d    = freq_m_q;
    freq_h_d    = freq_h_q;
    phinc_d     = phinc_q;
    ampl_d      = ampl_q;
    offs_d      = offs_q;
    if (wr_ok) begin
      case (reg_sel)
        RF_ADDR_CTRL: begin
          ctrl_en_d   = rf_data_i[CTRL_EN_BIT];
          ctrl_wave_d = rf_data_i[CTRL_WAVE_MSB:CTRL_WAVE_LSB];
        end
        RF_ADDR_FREQ_L: freq_l_d = rf_data_i;
        RF_ADDR_FREQ_M: freq_m_d = rf_data_i;
        RF_ADDR_FREQ_H: begin
          // The generator only ever sees a complete increment: H commits all three bytes.
          freq_h_d = rf_data_i;
          phinc_d  = {rf_data_i[7:0], freq_m_q[7:0], freq_l_q[7:0]};
        end
        RF_ADDR_AMPL:   ampl_d = rf_data_i;
        RF_ADDR_OFFS:   offs_d = rf_data_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      ctrl_en_q   <= 1'b0;
      ctrl_wave_q <= '0;
      freq_l_q    <= '0;
      freq_m_q    <= '0;
      freq_h_q    <= '0;
      phinc_q     <= '0;
      ampl_q      <= '0;
      offs_q      <= '0;
    end else begin
      ctrl_en_q   <= ctrl_en_d;
      ctrl_wave_q <= ctrl_wave_d;
      freq_l_q    <= freq_l_d;
      freq_m_q    <= freq_m_d;
      freq_h_q    <= freq_h_d;
      phinc_q     <= phinc_d;
      ampl_q      <= ampl_d;
      offs_q      <= offs_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux and data valid
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;
  logic                  rd_dv_d,   rd_dv_q;
  logic                  err_d,     err_q;

  always_comb begin
    rd_data_d = rd_data_q;
    rd_dv_d   = 1'b0;
    if (rd_ok) begin
      rd_dv_d   = 1'b1;
      rd_data_d = '0;
      if (addr_mapped) begin
        case (reg_sel)
          RF_ADDR_CTRL: begin
            rd_data_d[CTRL_EN_BIT]                 = ctrl_en_q;
            rd_data_d[CTRL_WAVE_MSB:CTRL_WAVE_LSB] = ctrl_wave_q;
          end
          RF_ADDR_STATUS: begin
            rd_data_d[STATUS_BUSY_BIT] = gen_busy_i;
            rd_data_d[STATUS_ERR_BIT]  = err_q;
          end
          RF_ADDR_FREQ_L: rd_data_d = freq_l_q;
          RF_ADDR_FREQ_M: rd_data_d = freq_m_q;
          RF_ADDR_FREQ_H: rd_data_d = freq_h_q;
          RF_ADDR_AMPL:   rd_data_d = ampl_q;
          RF_ADDR_OFFS:   rd_data_d = offs_q;
          RF_ADDR_ID:     rd_data_d = ID_VALUE;
          default:        rd_data_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      rd_data_q <= '0;
      rd_dv_q   <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_dv_q   <= rd_dv_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pulses and sticky error
  // ---------------------------------------------------------------------------
  logic start_d, start_q;
  logic upd_d,   upd_q;
  logic err_set;

  assign err_set = wr_err | rd_err | col_err;

  always_comb begin
    start_d = wr_ok & (reg_sel == RF_ADDR_CTRL) & rf_data_i[CTRL_START_BIT];
    upd_d   = wr_ok & is_update_reg(reg_sel);
    // A STATUS read clears ERR, but an error raised in the same cycle keeps it set.
    err_d   = err_set | (err_q & ~status_rd);
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      start_q <= 1'b0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= start_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rf_data_o   = rd_data_q;
  assign rf_rd_dv_o  = rd_dv_q;
  assign gen_en_o    = ctrl_en_q;
  assign gen_start_o = start_q;
  assign gen_wave_o  = ctrl_wave_q;
  assign gen_phinc_o = phinc_q;
  assign gen_ampl_o  = ampl_q;
  assign gen_offs_o  = offs_q;
  assign gen_upd_o   = upd_q;

endmodule
